// File: rtl/keypad_scan_fifo.sv
// Matrix keypad scanner: column-at-a-time scan, whole-frame debounce with ghost
// rejection, and a small key-event FIFO with valid/ready output.
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEBOUNCE   = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  input  logic            key_ready,
  output logic            key_pressed,
  output logic            multi_key,
  output logic            overflow
);

  localparam int N   = ROWS * COLS;
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int CIW = $clog2(COLS);
  localparam int SW  = $clog2(DEBOUNCE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int PW  = $clog2(N + 1);

  localparam logic [DW-1:0]  DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [CIW-1:0] COL_LAST    = CIW'(COLS - 1);
  localparam logic [SW-1:0]  STABLE_MAX  = SW'(DEBOUNCE - 1);
  localparam logic [SW-1:0]  STABLE_LOAD = SW'(DEBOUNCE - 2);
  localparam logic [AW:0]    FIFO_FULL   = (AW + 1)'(FIFO_DEPTH);

  function automatic logic [PW-1:0] popcnt(input logic [N-1:0] v);
    logic [PW-1:0] pc;
    pc = '0;
    for (int i = 0; i < N; i++) pc = pc + PW'(v[i]);
    return pc;
  endfunction

  logic [DW-1:0]   dwell;
  logic [CIW-1:0]  col_idx;
  logic [ROWS-1:0] row_act;
  logic [N-1:0]    snap;
  logic [N-1:0]    frame_cur;
  logic [N-1:0]    prev_frame;
  logic [N-1:0]    deb;
  logic [N-1:0]    deb_nxt;
  logic [SW-1:0]   stable_cnt;
  logic [SW-1:0]   stable_nxt;
  logic            sample;
  logic            frame_end;
  logic            deb_load;
  logic [PW-1:0]   new_cnt;
  logic            ev_push;
  logic [CW-1:0]   ev_code;
  logic            push_vld;
  logic [CW-1:0]   push_code;

  logic [CW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   rd_nxt;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic [AW:0]     remain;
  logic [CW-1:0]   head_nxt;
  logic            do_push;
  logic            do_pop;
  logic            full;

  assign row_act   = (ACTIVE_LOW != 0) ? ~row_in : row_in;
  assign sample    = (dwell == DWELL_LAST);
  assign frame_end = sample && (col_idx == COL_LAST);

  always_comb begin
    col_out = '0;
    for (int c = 0; c < COLS; c++)
      col_out[c] = (c == int'(col_idx)) ^ (ACTIVE_LOW != 0);
  end

  // Snapshot as it will look once the current column's rows are folded in.
  always_comb begin
    frame_cur = snap;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (c == int'(col_idx)) frame_cur[r*COLS + c] = row_act[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= '0;
      snap    <= '0;
    end else if (sample) begin
      dwell   <= '0;
      snap    <= frame_cur;
      col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + CIW'(1);
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  always_comb begin
    stable_nxt = stable_cnt;
    deb_load   = 1'b0;
    if (frame_cur == prev_frame) begin
      if (stable_cnt != STABLE_MAX) begin
        stable_nxt = stable_cnt + SW'(1);
        deb_load   = frame_end && (stable_cnt == STABLE_LOAD);
      end
    end else begin
      stable_nxt = '0;
    end
  end

  assign deb_nxt = deb_load ? frame_cur : deb;

  // Only a lone newly pressed key is reported; chords and holds stay silent.
  always_comb begin
    ev_code = '0;
    for (int i = 0; i < N; i++)
      if (deb_nxt[i]) ev_code = CW'(i);
    new_cnt = popcnt(deb_nxt);
    ev_push = deb_load && (new_cnt == PW'(1)) && ((deb_nxt & ~deb) != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt  <= '0;
      prev_frame  <= '0;
      deb         <= '0;
      push_vld    <= 1'b0;
      push_code   <= '0;
      key_pressed <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      if (frame_end) begin
        stable_cnt <= stable_nxt;
        prev_frame <= frame_cur;
      end
      deb         <= deb_nxt;
      push_vld    <= ev_push;
      push_code   <= ev_code;
      key_pressed <= |deb;
      multi_key   <= (popcnt(deb) >= PW'(2));
    end
  end

  assign full      = (count == FIFO_FULL);
  assign do_pop    = key_valid && key_ready;
  assign do_push   = push_vld && (!full || do_pop);
  assign count_nxt = count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
  assign rd_nxt    = rd_ptr + AW'(do_pop);
  assign remain    = count - (AW + 1)'(do_pop);
  // With nothing left behind the popped head, the incoming push becomes the head.
  assign head_nxt  = (remain == '0) ? push_code : mem[rd_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      rd_ptr    <= rd_nxt;
      count     <= count_nxt;
      key_valid <= (count_nxt != '0);
      if (count_nxt != '0) key_code <= head_nxt;
      if (push_vld && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: scan order, debounce, ghost rejection,
// FIFO ordering/overflow and asynchronous reset, driven by an ideal keypad model.
module tb_keypad_scan_fifo;
  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic        key_pressed;
  logic        multi_key;
  logic        overflow;
  logic [15:0] keys;

  int checks = 0;
  int errors = 0;
  logic [3:0] ev_q[$];

  typedef struct {
    int         edge_n;
    logic [3:0] col;
  } scan_t;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          n_ev;
    logic [3:0]  code;
    logic        pressed;
    logic        multi;
  } scen_t;

  scan_t scan_tab[9];
  scen_t scen_tab[8];
  logic [3:0] fifo_keys[5];

  keypad_scan_fifo #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE(3), .ACTIVE_LOW(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_pressed(key_pressed), .multi_key(multi_key), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4 + c] && !col_out[c]) row_in[r] = 1'b0;
  end

  always @(negedge clk)
    if (rst_n && key_valid && key_ready) ev_q.push_back(key_code);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic align();
    logic [3:0] prev;
    logic       found;
    prev  = col_out;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (prev == 4'b0111 && col_out == 4'b1110) found = 1'b1;
      prev = col_out;
    end
    check("frame_align", 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    scan_tab = '{'{0, 4'b1110}, '{3, 4'b1110}, '{4, 4'b1101}, '{7, 4'b1101},
                 '{8, 4'b1011}, '{11, 4'b1011}, '{12, 4'b0111}, '{15, 4'b0111},
                 '{16, 4'b1110}};
    scen_tab = '{'{16'h0200, 6, 1, 4'd9, 1'b1, 1'b0},
                 '{16'h0000, 5, 0, 4'd0, 1'b0, 1'b0},
                 '{16'h8001, 5, 0, 4'd0, 1'b1, 1'b1},
                 '{16'h0001, 5, 0, 4'd0, 1'b1, 1'b0},
                 '{16'h0000, 5, 0, 4'd0, 1'b0, 1'b0},
                 '{16'h0040, 5, 1, 4'd6, 1'b1, 1'b0},
                 '{16'h0440, 5, 0, 4'd0, 1'b1, 1'b1},
                 '{16'h0000, 5, 0, 4'd0, 1'b0, 1'b0}};
    fifo_keys = '{4'd3, 4'd5, 4'd7, 4'd11, 4'd13};

    rst_n     = 1'b0;
    keys      = '0;
    key_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col_out", 32'(col_out), 32'hE);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_flags", 32'({key_pressed, multi_key, overflow}), 32'd0);

    // Scan order after reset release
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      check("scan_key_valid", 32'(key_valid), 32'd0);
      for (int j = 0; j < 9; j++)
        if (scan_tab[j].edge_n == k) check("scan_col_out", 32'(col_out), 32'(scan_tab[j].col));
    end

    // Table-driven press/release/ghost scenarios, consumer always ready
    for (int s = 0; s < 8; s++) begin
      align();
      ev_q.delete();
      keys  = scen_tab[s].keys;
      first = -1;
      for (int cyc = 1; cyc <= scen_tab[s].frames * FRAME; cyc++) begin
        tick();
        if (key_valid && first < 0) first = cyc;
      end
      check("scen_event_count", 32'(ev_q.size()), 32'(scen_tab[s].n_ev));
      if (scen_tab[s].n_ev == 1 && ev_q.size() == 1) begin
        check("scen_event_code", 32'(ev_q[0]), 32'(scen_tab[s].code));
        checks++;
        if (first < 3*FRAME || first > 3*FRAME + 2) begin
          errors++;
          $display("FAIL scen_latency: first key_valid at cycle %0d required 48..50", first);
        end
      end
      check("scen_key_pressed", 32'(key_pressed), 32'(scen_tab[s].pressed));
      check("scen_multi_key", 32'(multi_key), 32'(scen_tab[s].multi));
      check("scen_overflow", 32'(overflow), 32'd0);
    end

    // Bounce: key 0 toggles every frame, then held
    align();
    ev_q.delete();
    for (int i = 0; i < 5; i++) begin
      keys = (i % 2 == 0) ? 16'h0001 : 16'h0000;
      run(FRAME);
    end
    check("bounce_no_event", 32'(ev_q.size()), 32'd0);
    check("bounce_not_pressed", 32'(key_pressed), 32'd0);
    keys = 16'h0001;
    run(3 * FRAME);
    check("bounce_one_event", 32'(ev_q.size()), 32'd1);
    if (ev_q.size() == 1) check("bounce_code", 32'(ev_q[0]), 32'd0);
    check("bounce_pressed", 32'(key_pressed), 32'd1);
    keys = 16'h0000;
    run(5 * FRAME);
    check("bounce_release_no_event", 32'(ev_q.size()), 32'd1);
    check("bounce_released", 32'(key_pressed), 32'd0);

    // FIFO fill and overflow with the consumer stalled
    key_ready = 1'b0;
    ev_q.delete();
    for (int i = 0; i < 5; i++) begin
      align();
      keys = 16'(1) << fifo_keys[i];
      run(4 * FRAME);
      keys = 16'h0000;
      run(4 * FRAME);
      if (i == 3) begin
        check("fifo_full_no_overflow", 32'(overflow), 32'd0);
        check("fifo_full_valid", 32'(key_valid), 32'd1);
        check("fifo_full_head", 32'(key_code), 32'd3);
      end
    end
    check("fifo_valid", 32'(key_valid), 32'd1);
    check("fifo_head_held", 32'(key_code), 32'd3);
    check("fifo_overflow", 32'(overflow), 32'd1);
    check("fifo_no_pop_while_stalled", 32'(ev_q.size()), 32'd0);
    key_ready = 1'b1;
    run(8);
    check("fifo_drain_count", 32'(ev_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < ev_q.size()) check("fifo_order", 32'(ev_q[i]), 32'(fifo_keys[i]));
    check("fifo_drained_valid", 32'(key_valid), 32'd0);
    check("fifo_overflow_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset with a key held and an event pending
    key_ready = 1'b0;
    align();
    keys = 16'h0200;
    run(4 * FRAME + 6);
    @(posedge clk);
    #3;
    check("pre_rst_valid", 32'(key_valid), 32'd1);
    check("pre_rst_code", 32'(key_code), 32'd9);
    check("pre_rst_pressed", 32'(key_pressed), 32'd1);
    check("pre_rst_col", 32'(col_out), 32'hD);
    rst_n = 1'b0;
    #1;
    check("async_rst_col_out", 32'(col_out), 32'hE);
    check("async_rst_key_valid", 32'(key_valid), 32'd0);
    check("async_rst_key_code", 32'(key_code), 32'd0);
    check("async_rst_pressed", 32'(key_pressed), 32'd0);
    check("async_rst_multi", 32'(multi_key), 32'd0);
    check("async_rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(2);
    check("post_rst_col_out", 32'(col_out), 32'hE);
    check("post_rst_key_valid", 32'(key_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
